// File: rtl/knob_scan_pkg.sv
// Shared types and hysteresis helpers for the potentiometer scanner.
package knob_scan_pkg;

  typedef enum logic [1:0] {IDLE, REQ, CMP, NEXT} state_t;

  // Helpers work on a fixed wide sample; callers zero-extend narrower ADC words.
  localparam int KS_MW = 16;
  typedef logic [KS_MW-1:0] samp_t;

  function automatic samp_t absdiff(samp_t a, samp_t b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  function automatic logic load_ok(logic valid, samp_t new_v, samp_t old_v,
                                   samp_t hyst, samp_t rail_hi);
    logic rail;
    rail = ((new_v == '0) || (new_v == rail_hi)) && (new_v != old_v);
    return !valid || (absdiff(new_v, old_v) >= hyst) || rail;
  endfunction

endpackage

// File: rtl/knob_scan_ctrl_if.sv
// Single-channel ADC request/ack handshake used by the potentiometer scanner.
interface knob_scan_ctrl_if #(
  parameter int M   = 10,
  parameter int NCH = 2
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  logic          adc_req;
  logic [CW-1:0] adc_chan;
  logic          adc_ack;
  logic [M-1:0]  adc_data;

  modport master (output adc_req, adc_chan, input adc_ack, adc_data);
  modport slave  (input adc_req, adc_chan, output adc_ack, adc_data);
endinterface

// File: rtl/knob_scan_ctrl_tick_gen.sv
// Free-running divider: tick is high for one clock every DIV clocks.
module tick_gen #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);
  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [TW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 cnt <= '0;
    else if (cnt == TW'(DIV - 1)) cnt <= '0;
    else                          cnt <= cnt + TW'(1);
  end

  assign tick = (cnt == TW'(DIV - 1));
endmodule

// File: rtl/knob_scan_ctrl.sv
// Round-robin potentiometer scanner: sole ADC master, hysteresis filter,
// one held value and one-cycle update strobe per channel.
//
//   state | meaning
//   IDLE  | waiting for a scan tick with scan_en high
//   REQ   | adc_req high for channel ch, waiting for ack or timeout
//   CMP   | apply hysteresis rule to the captured sample
//   NEXT  | advance to the next channel or finish the scan
module knob_scan_ctrl
  import knob_scan_pkg::*;
#(
  parameter int M        = 10,
  parameter int NCH      = 2,
  parameter int HYST     = 4,
  parameter int SCAN_DIV = 50000,
  parameter int TMO      = 255
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                scan_en,
  knob_scan_ctrl_if.master    adc,
  output logic [NCH*M-1:0]    knob_val,
  output logic [NCH-1:0]      upd,
  output logic                busy,
  output logic                err_tmo
);
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int WW = (TMO > 0) ? $clog2(TMO + 1) : 1;

  state_t        state, state_nxt;
  logic [CW-1:0] ch;
  logic [WW-1:0] wait_cnt;
  logic [M-1:0]  cap;
  logic [M-1:0]  old_v;
  logic [NCH-1:0] valid;
  logic          tick;
  logic          timeout;
  logic          last_ch;
  logic          load;

  tick_gen #(.DIV(SCAN_DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  assign timeout = (wait_cnt == WW'(TMO));
  assign last_ch = (ch == CW'(NCH - 1));
  assign old_v   = knob_val[int'(ch)*M +: M];
  assign load    = load_ok(valid[ch], samp_t'(cap), samp_t'(old_v),
                           samp_t'(HYST), samp_t'((1 << M) - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (tick && scan_en) state_nxt = REQ;
      REQ: begin
        if (adc.adc_ack)  state_nxt = CMP;
        else if (timeout) state_nxt = NEXT;
      end
      CMP:  state_nxt = NEXT;
      NEXT: state_nxt = last_ch ? IDLE : REQ;
      default: state_nxt = IDLE;
    endcase
  end

  // Request is decoded straight from the state so an async reset drops it at once.
  assign adc.adc_req  = (state == REQ);
  assign adc.adc_chan = ch;
  assign busy         = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ch       <= '0;
      wait_cnt <= '0;
      cap      <= '0;
      valid    <= '0;
      knob_val <= '0;
      upd      <= '0;
      err_tmo  <= 1'b0;
    end else begin
      upd      <= '0;
      wait_cnt <= '0;
      unique case (state)
        IDLE: if (tick && scan_en) ch <= '0;
        REQ: begin
          if (adc.adc_ack)  cap <= adc.adc_data;
          else if (timeout) err_tmo <= 1'b1;
          else              wait_cnt <= wait_cnt + WW'(1);
        end
        CMP: begin
          if (load) begin
            knob_val[int'(ch)*M +: M] <= cap;
            upd[ch]   <= 1'b1;
            valid[ch] <= 1'b1;
          end
        end
        NEXT: if (!last_ch) ch <= ch + CW'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_knob_scan_ctrl.sv
// Randomized bench for knob_scan_ctrl against a cycle-level behavioural model.
module tb_knob_scan_ctrl;
  localparam int M    = 10;
  localparam int NCH  = 2;
  localparam int HYST = 4;
  localparam int DIV  = 100;
  localparam int TMO  = 20;
  localparam int RAIL = (1 << M) - 1;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic scan_en = 1'b0;
  logic [NCH*M-1:0] knob_val;
  logic [NCH-1:0]   upd;
  logic             busy;
  logic             err_tmo;

  knob_scan_ctrl_if #(.M(M), .NCH(NCH)) adc ();

  knob_scan_ctrl #(
    .M(M), .NCH(NCH), .HYST(HYST), .SCAN_DIV(DIV), .TMO(TMO)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .scan_en  (scan_en),
    .adc      (adc),
    .knob_val (knob_val),
    .upd      (upd),
    .busy     (busy),
    .err_tmo  (err_tmo)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [M-1:0] kv(int k);
    return knob_val[k*M +: M];
  endfunction

  // ADC stimulus knobs, written by the main sequence
  int val [NCH];
  bit hold [NCH];
  int lat;
  bit stray_en;

  // ADC responder: acks `lat` clocks after req unless the channel is held off
  initial begin
    int wcnt;
    bit acked;
    wcnt = 0;
    acked = 0;
    adc.adc_ack  = 1'b0;
    adc.adc_data = '0;
    forever begin
      @(posedge clk);
      #1;
      adc.adc_ack = 1'b0;
      if (reset_n && adc.adc_req) begin
        if (!acked) begin
          wcnt++;
          if (!hold[adc.adc_chan] && wcnt >= lat) begin
            adc.adc_ack  = 1'b1;
            adc.adc_data = M'(val[adc.adc_chan]);
            acked = 1;
          end
        end
      end else begin
        wcnt = 0;
        acked = 0;
        if (reset_n && stray_en && $urandom_range(0, 5) == 0) begin
          adc.adc_ack  = 1'b1;
          adc.adc_data = M'($urandom);
        end
      end
    end
  end

  // Posedges since reset release; the scan divider must track this modulo DIV
  int ecnt;
  initial begin
    ecnt = 0;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) ecnt = 0;
      else          ecnt++;
    end
  end

  // Behavioural model, sampled on the falling edge. Event delays in samples:
  // ack -> req low +1, value/upd +2, next channel or idle +3;
  // timeout -> req low and err +1, next channel or idle +2; tick -> start +1.
  initial begin
    int mk [NCH];
    bit mv [NCH];
    bit m_req, m_busy, m_err;
    int m_ch, run;
    logic [NCH-1:0] m_upd;
    int c_start, c_off, c_err, c_upd, c_nxt;
    int cap_d, d;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        for (int k = 0; k < NCH; k++) begin mk[k] = 0; mv[k] = 0; end
        m_req = 0; m_busy = 0; m_err = 0; m_ch = 0; run = 0; m_upd = '0;
        c_start = 0; c_off = 0; c_err = 0; c_upd = 0; c_nxt = 0; cap_d = 0;
        continue;
      end
      m_upd = '0;
      if (c_start > 0) begin
        c_start--;
        if (c_start == 0) begin m_req = 1; m_ch = 0; m_busy = 1; run = 0; end
      end
      if (c_off > 0) begin c_off--; if (c_off == 0) m_req = 0; end
      if (c_err > 0) begin c_err--; if (c_err == 0) m_err = 1; end
      if (c_upd > 0) begin
        c_upd--;
        if (c_upd == 0) begin
          d = (cap_d > mk[m_ch]) ? cap_d - mk[m_ch] : mk[m_ch] - cap_d;
          if (!mv[m_ch] || d >= HYST ||
              ((cap_d == 0 || cap_d == RAIL) && cap_d != mk[m_ch])) begin
            mk[m_ch] = cap_d;
            mv[m_ch] = 1;
            m_upd[m_ch] = 1'b1;
          end
        end
      end
      if (c_nxt > 0) begin
        c_nxt--;
        if (c_nxt == 0) begin
          if (m_ch == NCH - 1) m_busy = 0;
          else begin m_ch++; m_req = 1; run = 0; end
        end
      end
      if (m_req) run++;

      chk("adc_req", adc.adc_req, m_req);
      if (m_req) chk("adc_chan", adc.adc_chan, m_ch);
      chk("upd", upd, m_upd);
      for (int k = 0; k < NCH; k++) chk("knob_val", kv(k), mk[k]);
      chk("busy", busy, m_busy);
      chk("err_tmo", err_tmo, m_err);

      if (m_req && c_off == 0) begin
        if (adc.adc_ack) begin
          cap_d = int'(adc.adc_data);
          c_off = 1; c_upd = 2; c_nxt = 3;
        end else if (run == TMO + 1) begin
          c_off = 1; c_err = 1; c_nxt = 2;
        end
      end
      if (!m_busy && c_start == 0 && scan_en && (ecnt % DIV) == DIV - 1) c_start = 1;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin @(posedge clk); #3; n++; end
    chk("scan_end", busy, 0);
  endtask

  task automatic run_scan();
    int n = 0;
    while (!busy && n < 300) begin @(posedge clk); #3; n++; end
    chk("scan_start", busy, 1);
    wait_idle();
  endtask

  task automatic wait_req_ch0();
    int n = 0;
    while (!(adc.adc_req && adc.adc_chan == 0) && n < 300) begin @(posedge clk); #3; n++; end
    chk("req_ch0_seen", adc.adc_req, 1);
  endtask

  initial begin
    int hi_cycles;
    val = '{300, 700};
    hold = '{0, 0};
    lat = 5;
    stray_en = 0;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk("rst_req", adc.adc_req, 0);
    chk("rst_chan", adc.adc_chan, 0);
    chk("rst_knob", knob_val, 0);
    chk("rst_upd", upd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_tmo, 0);
    reset_n = 1'b1;
    @(posedge clk); #3;
    scan_en = 1'b1;

    run_scan(); chk("first_k0", kv(0), 300); chk("first_k1", kv(1), 700);
    val[0] = 302;  run_scan(); chk("hyst_hold_302", kv(0), 300);
    val[0] = 304;  run_scan(); chk("hyst_load_304", kv(0), 304);
    val[0] = 301;  run_scan(); chk("hyst_hold_301", kv(0), 304);
    val[1] = 1022; run_scan(); chk("step_1022", kv(1), 1022);
    val[1] = 1023; run_scan(); chk("rail_hi", kv(1), 1023);
    val[1] = 2;    run_scan(); chk("drop_to_2", kv(1), 2);
    val[1] = 0;    run_scan(); chk("rail_lo", kv(1), 0);

    hold[0] = 1; val[1] = 500; stray_en = 1;
    run_scan();
    chk("tmo_err", err_tmo, 1);
    chk("tmo_k0_kept", kv(0), 304);
    chk("tmo_k1_conv", kv(1), 500);
    hold[0] = 0;

    val[1] = 600;
    wait_req_ch0();
    scan_en = 1'b0;
    wait_idle();
    chk("disable_k1_done", kv(1), 600);
    hi_cycles = 0;
    repeat (250) begin @(posedge clk); #3; if (adc.adc_req) hi_cycles++; end
    chk("disable_no_req", hi_cycles, 0);

    scan_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < NCH; k++) begin
        case ($urandom_range(0, 3))
          0: val[k] = $urandom_range(0, RAIL);
          1: begin
            val[k] = val[k] + $urandom_range(0, 12) - 6;
            if (val[k] < 0) val[k] = 0;
            if (val[k] > RAIL) val[k] = RAIL;
          end
          2: val[k] = ($urandom_range(0, 1) == 1) ? RAIL : 0;
          default: ;
        endcase
        hold[k] = ($urandom_range(0, 9) == 0);
      end
      lat = $urandom_range(1, 8);
      run_scan();
    end

    hold = '{0, 0};
    lat = 5;
    val = '{5, 1020};
    run_scan();
    wait_req_ch0();
    reset_n = 1'b0;
    #1;
    chk("midrst_req", adc.adc_req, 0);
    chk("midrst_knob", knob_val, 0);
    chk("midrst_upd", upd, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_err", err_tmo, 0);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    val = '{6, 1021};
    run_scan();
    chk("reload_k0", kv(0), 6);
    chk("reload_k1", kv(1), 1021);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
